// File: rtl/alu_rr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rr_sequencer
//  Purpose  : Hardwired control sequencer. Fetches one instruction (T0-T2) and
//             executes a register-register ALU op (T3-T5), with an extra T6
//             step for MUL/DIV to write back HI/LO. All outputs are registered
//             Moore decodes of the state being entered.
//  Options  : MICROSTEP_EN - adds a Step input; every transition out of T0-T6
//             also requires Step=1, and the T1 wait counter is frozen while
//             waiting for it.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_rr_sequencer #(
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 16,
   parameter int OP_W        = 5,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                Clock,
   input  logic                Clear,
   input  logic                Start,
   input  logic                MemReady,
`ifdef MICROSTEP_EN
   input  logic                Step,
`endif
   input  logic [DATA_W-1:0]   IR,
   output logic                PCout,
   output logic                MARin,
   output logic                IncPC,
   output logic                Read,
   output logic                MDRin,
   output logic                MDRout,
   output logic                IRin,
   output logic                Yin,
   output logic                ZLowIn,
   output logic                ZHighIn,
   output logic                Zlowout,
   output logic                ZHighout,
   output logic                HIin,
   output logic                LOin,
   output logic [NUM_REGS-1:0] Rout,
   output logic [NUM_REGS-1:0] Rin,
   output logic [OP_W-1:0]     alu_op,
   output logic                Busy,
   output logic                Done,
   output logic                Fault
);

   // IR field positions are hardwired, so only this geometry is buildable
   if (DATA_W != 32) begin : g_bad_data_w
      $error("alu_rr_sequencer: DATA_W must be 32");
   end
   if (OP_W != 5) begin : g_bad_op_w
      $error("alu_rr_sequencer: OP_W must be 5");
   end
   if (NUM_REGS < 2 || NUM_REGS > 16) begin : g_bad_num_regs
      $error("alu_rr_sequencer: NUM_REGS must be 2..16");
   end
   if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
      $error("alu_rr_sequencer: MEM_TIMEOUT must be 1..255");
   end

   localparam logic [OP_W-1:0] C_OP_ADD = 5'b00011;
   localparam logic [OP_W-1:0] C_OP_SUB = 5'b00100;
   localparam logic [OP_W-1:0] C_OP_AND = 5'b00101;
   localparam logic [OP_W-1:0] C_OP_OR  = 5'b00110;
   localparam logic [OP_W-1:0] C_OP_SHR = 5'b00111;
   localparam logic [OP_W-1:0] C_OP_SHL = 5'b01000;
   localparam logic [OP_W-1:0] C_OP_ROR = 5'b01001;
   localparam logic [OP_W-1:0] C_OP_ROL = 5'b01010;
   localparam logic [OP_W-1:0] C_OP_MUL = 5'b01111;
   localparam logic [OP_W-1:0] C_OP_DIV = 5'b10000;
   localparam logic [4:0]      C_NREGS     = 5'(NUM_REGS);
   localparam logic [7:0]      C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
      S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_DONE = 4'd8
   } state_t;

   typedef struct packed {
      logic pcout, marin, incpc, read, mdrin, mdrout, irin, yin;
      logic zlowin, zhighin, zlowout, zhighout, hiin, loin;
   } strobe_t;

   state_t              state_q, state_d;
   logic                fault_q, fault_d;
   logic [7:0]          wait_q, wait_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [3:0]          ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   strobe_t             strb_q, strb_d;
   logic [NUM_REGS-1:0] rout_q, rout_d, rin_q, rin_d;
   logic [OP_W-1:0]     aluop_q, aluop_d;
   logic                busy_q, busy_d, done_q, done_d;

   logic [OP_W-1:0]     w_ir_op;
   logic [3:0]          w_ir_ra, w_ir_rb, w_ir_rc;
   logic                w_op_legal, w_decode_ok, w_step;
   logic                unused_ir_low;

   assign w_ir_op       = IR[31:27];
   assign w_ir_ra       = IR[26:23];
   assign w_ir_rb       = IR[22:19];
   assign w_ir_rc       = IR[18:15];
   assign unused_ir_low = ^IR[14:0];

`ifdef MICROSTEP_EN
   assign w_step = Step;
`else
   assign w_step = 1'b1;
`endif

   function automatic logic f_is_muldiv(input logic [OP_W-1:0] op);
      return (op == C_OP_MUL) || (op == C_OP_DIV);
   endfunction

   function automatic logic [NUM_REGS-1:0] f_onehot(input logic [3:0] idx);
      return NUM_REGS'(1) << idx;
   endfunction

   // Opcode legality check on the freshly loaded instruction
   always_comb begin
      case (w_ir_op)
         C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR, C_OP_SHR,
         C_OP_SHL, C_OP_ROR, C_OP_ROL, C_OP_MUL, C_OP_DIV: w_op_legal = 1'b1;
         default:                                          w_op_legal = 1'b0;
      endcase
   end

   // Ra is only a destination for non-MUL/DIV ops, so only then must it exist
   assign w_decode_ok = w_op_legal
                        && ({1'b0, w_ir_rb} < C_NREGS)
                        && ({1'b0, w_ir_rc} < C_NREGS)
                        && (f_is_muldiv(w_ir_op) || ({1'b0, w_ir_ra} < C_NREGS));

   // Next state, sticky fault, T1 wait counter and instruction field latch
   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      wait_d  = wait_q;
      op_d    = op_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rc_d    = rc_q;
      case (state_q)
         S_IDLE: if (Start && !fault_q) state_d = S_T0;
         S_T0:   if (w_step) state_d = S_T1;
         S_T1: begin
            if (w_step) begin
               if (MemReady) begin
                  state_d = S_T2;
                  wait_d  = '0;
               end else if (wait_q == C_WAIT_LAST) begin
                  fault_d = 1'b1;
                  state_d = S_IDLE;
                  wait_d  = '0;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end
         end
         S_T2: begin
            // IR is decoded here so the T3 strobes can be registered;
            // a bad instruction enters T3 already faulted and drives nothing
            if (w_step) begin
               state_d = S_T3;
               op_d    = w_ir_op;
               ra_d    = w_ir_ra;
               rb_d    = w_ir_rb;
               rc_d    = w_ir_rc;
               if (!w_decode_ok) fault_d = 1'b1;
            end
         end
         S_T3:   if (w_step) state_d = fault_q ? S_IDLE : S_T4;
         S_T4:   if (w_step) state_d = S_T5;
         S_T5:   if (w_step) state_d = f_is_muldiv(op_q) ? S_T6 : S_DONE;
         S_T6:   if (w_step) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore output decode of the state about to be entered
   always_comb begin
      strb_d  = '0;
      rout_d  = '0;
      rin_d   = '0;
      aluop_d = '0;
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      case (state_d)
         S_T0: begin
            strb_d.pcout  = 1'b1;
            strb_d.marin  = 1'b1;
            strb_d.incpc  = 1'b1;
            strb_d.zlowin = 1'b1;
         end
         S_T1: begin
            strb_d.zlowout = 1'b1;
            strb_d.incpc   = 1'b1;
            strb_d.read    = 1'b1;
            strb_d.mdrin   = 1'b1;
         end
         S_T2: begin
            strb_d.mdrout = 1'b1;
            strb_d.irin   = 1'b1;
         end
         S_T3: begin
            if (!fault_d) begin
               strb_d.yin = 1'b1;
               rout_d     = f_onehot(rb_d);
            end
         end
         S_T4: begin
            rout_d         = f_onehot(rc_d);
            aluop_d        = op_d;
            strb_d.zlowin  = 1'b1;
            strb_d.zhighin = f_is_muldiv(op_d);
         end
         S_T5: begin
            strb_d.zlowout = 1'b1;
            if (f_is_muldiv(op_d)) strb_d.loin = 1'b1;
            else                   rin_d       = f_onehot(ra_d);
         end
         S_T6: begin
            strb_d.zhighout = 1'b1;
            strb_d.hiin     = 1'b1;
         end
         default: ;
      endcase
   end

   // State, latched fields and registered outputs; Clear aborts immediately
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q <= S_IDLE;
         fault_q <= 1'b0;
         wait_q  <= '0;
         op_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
         strb_q  <= '0;
         rout_q  <= '0;
         rin_q   <= '0;
         aluop_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
         wait_q  <= wait_d;
         op_q    <= op_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rc_q    <= rc_d;
         strb_q  <= strb_d;
         rout_q  <= rout_d;
         rin_q   <= rin_d;
         aluop_q <= aluop_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign PCout    = strb_q.pcout;
   assign MARin    = strb_q.marin;
   assign IncPC    = strb_q.incpc;
   assign Read     = strb_q.read;
   assign MDRin    = strb_q.mdrin;
   assign MDRout   = strb_q.mdrout;
   assign IRin     = strb_q.irin;
   assign Yin      = strb_q.yin;
   assign ZLowIn   = strb_q.zlowin;
   assign ZHighIn  = strb_q.zhighin;
   assign Zlowout  = strb_q.zlowout;
   assign ZHighout = strb_q.zhighout;
   assign HIin     = strb_q.hiin;
   assign LOin     = strb_q.loin;
   assign Rout     = rout_q;
   assign Rin      = rin_q;
   assign alu_op   = aluop_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Fault    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_rr_sequencer
//  Purpose  : Directed and randomized bench for alu_rr_sequencer. Expected
//             strobes per cycle come from a phase list built from the
//             instruction's rules; a small datapath driven by the strobes
//             checks that operands and results are routed correctly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_sequencer;
   localparam int NR     = 8;
   localparam int MEM_TO = 15;

   localparam logic [13:0] M_PCOUT = 14'h2000, M_MARIN = 14'h1000, M_INCPC = 14'h0800;
   localparam logic [13:0] M_READ  = 14'h0400, M_MDRIN = 14'h0200, M_MDROUT = 14'h0100;
   localparam logic [13:0] M_IRIN  = 14'h0080, M_YIN = 14'h0040, M_ZLOWIN = 14'h0020;
   localparam logic [13:0] M_ZHIGHIN = 14'h0010, M_ZLOWOUT = 14'h0008, M_ZHIGHOUT = 14'h0004;
   localparam logic [13:0] M_HIIN  = 14'h0002, M_LOIN = 14'h0001;
   localparam logic [4:0]  OP_MUL = 5'b01111, OP_DIV = 5'b10000;

   typedef struct packed {
      logic [13:0]   s;
      logic [NR-1:0] rout;
      logic [NR-1:0] rin;
      logic [4:0]    alu;
      logic          busy, done, fault;
   } vec_t;

   logic          Clock = 1'b0;
   logic          Clear, Start, MemReady;
   logic [31:0]   IR;
   logic          PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin;
   logic          ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin;
   logic [NR-1:0] Rout, Rin;
   logic [4:0]    alu_op;
   logic          Busy, Done, Fault;
   vec_t          obs;

   int total = 0;
   int bad   = 0;

   logic [31:0] rf [NR];
   logic [31:0] dp_y, dp_zlo, dp_zhi, dp_hi, dp_lo;

   always #5 Clock = ~Clock;

   alu_rr_sequencer #(.DATA_W(32), .NUM_REGS(NR), .OP_W(5), .MEM_TIMEOUT(MEM_TO)) dut (
      .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady),
`ifdef MICROSTEP_EN
      .Step(1'b1),
`endif
      .IR(IR), .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
      .ZHighIn(ZHighIn), .Zlowout(Zlowout), .ZHighout(ZHighout), .HIin(HIin),
      .LOin(LOin), .Rout(Rout), .Rin(Rin), .alu_op(alu_op), .Busy(Busy),
      .Done(Done), .Fault(Fault)
   );

   assign obs = {PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, ZHighIn,
                 Zlowout, ZHighout, HIin, LOin, Rout, Rin, alu_op, Busy, Done, Fault};

   // Reference ALU: {HI, LO} result of an operation on Y (a) and bus (b)
   function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         5'b00011: alu = {32'd0, a + b};
         5'b00100: alu = {32'd0, a - b};
         5'b00101: alu = {32'd0, a & b};
         5'b00110: alu = {32'd0, a | b};
         5'b00111: alu = {32'd0, a >> sh};
         5'b01000: alu = {32'd0, a << sh};
         5'b01001: alu = {32'd0, (a >> sh) | (a << (32 - int'(sh)))};
         5'b01010: alu = {32'd0, (a << sh) | (a >> (32 - int'(sh)))};
         5'b01111: alu = {32'd0, a} * {32'd0, b};
         5'b10000: alu = (b == 32'd0) ? 64'd0 : {a % b, a / b};
         default:  alu = 64'd0;
      endcase
   endfunction

   // Tiny datapath that obeys the strobes mid-cycle
   always @(negedge Clock) begin : p_datapath
      logic [31:0] bus;
      logic [63:0] res;
      bus = 32'd0;
      if (Zlowout)  bus = dp_zlo;
      if (ZHighout) bus = dp_zhi;
      if (MDRout)   bus = IR;
      for (int i = 0; i < NR; i++) if (Rout[i]) bus = rf[i];
      if (Yin) dp_y = bus;
      if (ZLowIn || ZHighIn) begin
         res = (alu_op == 5'd0) ? {32'd0, bus + 32'd1} : alu(alu_op, dp_y, bus);
         if (ZLowIn)  dp_zlo = res[31:0];
         if (ZHighIn) dp_zhi = res[63:32];
      end
      if (LOin) dp_lo = bus;
      if (HIin) dp_hi = bus;
      for (int i = 0; i < NR; i++) if (Rin[i]) rf[i] = bus;
   end

   function automatic bit is_md(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic bit decode_bad(input logic [31:0] ir);
      logic [4:0] op;
      op = ir[31:27];
      if (!(op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                       5'b01000, 5'b01001, 5'b01010, 5'b01111, 5'b10000})) return 1'b1;
      if (int'(ir[22:19]) >= NR || int'(ir[18:15]) >= NR) return 1'b1;
      return !is_md(op) && int'(ir[26:23]) >= NR;
   endfunction

   // Expected outputs for a named phase of the instruction
   function automatic vec_t mk(input string ph, input logic [31:0] ir);
      vec_t v;
      bit   md;
      v  = '0;
      md = is_md(ir[31:27]);
      if (ph == "T0") v.s = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
      else if (ph == "T1") v.s = M_ZLOWOUT | M_INCPC | M_READ | M_MDRIN;
      else if (ph == "T2") v.s = M_MDROUT | M_IRIN;
      else if (ph == "T3") begin
         v.s = M_YIN;  v.rout = NR'(1) << ir[22:19];
      end else if (ph == "T4") begin
         v.s = M_ZLOWIN | (md ? M_ZHIGHIN : 14'd0);
         v.rout = NR'(1) << ir[18:15];
         v.alu = ir[31:27];
      end else if (ph == "T5") begin
         v.s = M_ZLOWOUT | (md ? M_LOIN : 14'd0);
         if (!md) v.rin = NR'(1) << ir[26:23];
      end else if (ph == "T6") v.s = M_ZHIGHOUT | M_HIIN;
      else if (ph == "DONE") v.done = 1'b1;
      v.busy  = !(ph == "IDLE" || ph == "IDLEF");
      v.fault = (ph == "T3F" || ph == "IDLEF");
      return v;
   endfunction

   task automatic check(input string tag, input vec_t exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Drive one instruction with w memory wait cycles and check every cycle
   task automatic run_instr(input string tag, input logic [31:0] ir, input int w,
                            input bit hold, input int abort_at, output int busy_n);
      string ph[$];
      bit    badf;
      badf = decode_bad(ir);
      ph.push_back("T0");
      if (w >= MEM_TO) begin
         repeat (MEM_TO) ph.push_back("T1");
         ph.push_back("IDLEF");
      end else begin
         repeat (w + 1) ph.push_back("T1");
         ph.push_back("T2");
         if (badf) begin
            ph.push_back("T3F");  ph.push_back("IDLEF");
         end else begin
            ph.push_back("T3");  ph.push_back("T4");  ph.push_back("T5");
            if (is_md(ir[31:27])) ph.push_back("T6");
            ph.push_back("DONE");  ph.push_back("IDLE");
         end
      end
      IR     = ir;
      busy_n = 0;
      for (int n = 1; n <= ph.size(); n++) begin
         @(negedge Clock);
         Start    = hold || (n == 1);
         MemReady = (n >= w + 3);
         @(posedge Clock);
         #1;
         check($sformatf("%s_c%0d_%s", tag, n, ph[n-1]), mk(ph[n-1], ir));
         if (Busy) busy_n++;
         if (n == abort_at) begin
            #2 Clear = 1'b1;
            #1 check({tag, "_clear"}, mk("IDLE", ir));
            @(negedge Clock);
            Clear = 1'b0;
            break;
         end
      end
      @(negedge Clock);
      Start    = 1'b0;
      MemReady = 1'b0;
   endtask

   // Run an instruction and check the architectural result it leaves behind
   task automatic exec(input string tag, input logic [31:0] ir, input int w,
                       input bit hold, output bit faulted, output int busy_n);
      logic [63:0] e;
      logic [2:0]  ra, rb, rc;
      ra = ir[25:23];  rb = ir[21:19];  rc = ir[17:15];
      faulted = decode_bad(ir) || (w >= MEM_TO);
      e = alu(ir[31:27], rf[rb], rf[rc]);
      run_instr(tag, ir, w, hold, 0, busy_n);
      if (!faulted) begin
         if (is_md(ir[31:27])) check_val({tag, "_hilo"}, {dp_hi, dp_lo}, e);
         else                  check_val({tag, "_rd"}, {32'd0, rf[ra]}, e);
      end
   endtask

   task automatic do_clear();
      @(negedge Clock);
      Clear = 1'b1;
      @(posedge Clock);
      #1 check("clear", mk("IDLE", 32'd0));
      @(negedge Clock);
      Clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  ops [10] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                               5'b01000, 5'b01001, 5'b01010, 5'b01111, 5'b10000};
      logic [31:0] ir;
      logic [4:0]  op;
      bit          flt;
      int          bn, w, k;

      Clear = 1'b1;  Start = 1'b0;  MemReady = 1'b0;  IR = 32'd0;
      for (int i = 0; i < NR; i++) rf[i] = $urandom;
      repeat (2) @(posedge Clock);
      #1 check("reset", mk("IDLE", 32'd0));
      @(negedge Clock);
      Clear = 1'b0;

      // Clear in the middle of T4 of OR R1,R2,R3, then a normal OR
      rf[2] = 32'h0C;  rf[3] = 32'h05;  rf[1] = 32'h0;
      run_instr("or_abort", 32'h3091_8000, 0, 1'b0, 5, bn);
      check_val("or_abort_r1", {32'd0, rf[1]}, 64'h0);
      exec("or", 32'h3091_8000, 0, 1'b0, flt, bn);
      check_val("or_busy_cycles", 64'(bn), 64'd7);
      check_val("or_r1", {32'd0, rf[1]}, 64'h0D);
      exec("and", 32'h2891_8000, 0, 1'b0, flt, bn);
      check_val("and_r1", {32'd0, rf[1]}, 64'h04);

      // Memory waits: 3 cycles, last tolerated wait, and timeout
      exec("wait3", 32'h1A29_8000, 3, 1'b1, flt, bn);
      exec("wait14", 32'h2391_0000, 14, 1'b0, flt, bn);
      exec("timeout", 32'h3091_8000, 100, 1'b0, flt, bn);
      do_clear();

      // MUL 0x10000 * 0x10000 -> HI=1, LO=0, no Rin
      rf[2] = 32'h0001_0000;  rf[3] = 32'h0001_0000;
      exec("mul", 32'h7891_8000, 0, 1'b0, flt, bn);
      check_val("mul_lo", {32'd0, dp_lo}, 64'd0);
      check_val("mul_hi", {32'd0, dp_hi}, 64'd1);

      // Illegal opcode: fault in T3, later Starts ignored until Clear
      exec("illegal", 32'hF891_8000, 0, 1'b0, flt, bn);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         Start = 1'b1;
         @(posedge Clock);
         #1 check($sformatf("ignored_%0d", i), mk("IDLEF", 32'd0));
      end
      @(negedge Clock);
      Start = 1'b0;
      do_clear();

      // Ra=9 is beyond an 8-register file
      exec("ra9", 32'h1C91_8000, 0, 1'b0, flt, bn);
      do_clear();

      // Randomized instruction mix
      for (int t = 0; t < 40; t++) begin
         k  = $urandom_range(0, 10);
         op = (k == 10) ? 5'($urandom) : ops[k];
         ir = {op, 4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)),
               4'($urandom_range(0, 8)), 15'($urandom)};
         w  = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
         exec($sformatf("rnd%0d", t), ir, w, 1'($urandom), flt, bn);
         if (flt) do_clear();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
